// File: rtl/xnor_based_borrow_serial_subtractor32.sv
// Chunk-serial approximate subtractor: result = minuend - subtrahend, CHUNK bits per cycle.
// The borrow chain is exact everywhere. The low LOWER_WIDTH difference bits come from an
// XNOR cell that drops the borrow-in. The upper bits are exact.
// Optional feature macro: XNOR_SUB_ERROR_METRIC_EN adds the err_mask_o / err_flag_o ports.
// These ports report where the approximate result differs from the exact one.
module xnor_based_borrow_serial_subtractor32 #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned LOWER_WIDTH = 8,
  parameter int unsigned CHUNK       = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] min_i,
  input  logic [WIDTH-1:0] sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH:0]   result_o,
  output logic             busy_o
`ifdef XNOR_SUB_ERROR_METRIC_EN
  ,
  output logic [WIDTH:0]   err_mask_o,
  output logic             err_flag_o
`endif
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IDX_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] CHUNK_ONES = WIDTH'({CHUNK{1'b1}});

  // Elaboration-time parameter sanity
  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("WIDTH must be a multiple of CHUNK");
  end
  if (LOWER_WIDTH > WIDTH) begin : g_bad_lower
    $error("LOWER_WIDTH must not exceed WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q;
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] sub_q;

  logic [IDX_W-1:0] chunk_base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] diff_chunk;
  logic             prop;
  logic             br;
  logic             br_next;
  logic [WIDTH-1:0] diff_next;
  logic             last_chunk;

`ifdef XNOR_SUB_ERROR_METRIC_EN
  logic [CHUNK-1:0] exact_chunk;
  logic [WIDTH-1:0] mask_next;
  logic             flag_next;
`endif

  // Current chunk: ripple the borrow across its bits and build the approximate/exact diffs
  always_comb begin
    chunk_base = IDX_W'(cnt_q) * IDX_W'(CHUNK);
    a_chunk    = CHUNK'(min_q >> chunk_base);
    b_chunk    = CHUNK'(sub_q >> chunk_base);
    diff_chunk = '0;
    prop       = 1'b0;
    br         = br_q;
`ifdef XNOR_SUB_ERROR_METRIC_EN
    exact_chunk = '0;
`endif
    for (int unsigned j = 0; j < CHUNK; j++) begin
      prop = a_chunk[j] ^ b_chunk[j];
      if ((chunk_base + IDX_W'(j)) < IDX_W'(LOWER_WIDTH)) begin
        // XNOR cell, inverted: the borrow-in does not reach the diff bit
        diff_chunk[j] = ~(a_chunk[j] ~^ b_chunk[j]);
      end else begin
        diff_chunk[j] = prop ^ br;
      end
`ifdef XNOR_SUB_ERROR_METRIC_EN
      exact_chunk[j] = prop ^ br;
`endif
      br = (~a_chunk[j] & b_chunk[j]) | (~prop & br);
    end
    br_next    = br;
    last_chunk = (cnt_q == CNT_W'(N - 1));
    diff_next  = (result_o[WIDTH-1:0] & ~(CHUNK_ONES << chunk_base))
               | (WIDTH'(diff_chunk) << chunk_base);
  end

`ifdef XNOR_SUB_ERROR_METRIC_EN
  // Error mask for this chunk merged into the held mask; the flag covers the full word
  always_comb begin
    mask_next = (err_mask_o[WIDTH-1:0] & ~(CHUNK_ONES << chunk_base))
              | (WIDTH'(diff_chunk ^ exact_chunk) << chunk_base);
    flag_next = |mask_next;
  end
`endif

  // Control FSM, operand capture and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      min_q    <= '0;
      sub_q    <= '0;
      ready_o  <= 1'b1;
      valid_o  <= 1'b0;
      busy_o   <= 1'b0;
      result_o <= '0;
`ifdef XNOR_SUB_ERROR_METRIC_EN
      err_mask_o <= '0;
      err_flag_o <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_i && ready_o) begin
            min_q   <= min_i;
            sub_q   <= sub_i;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          result_o[WIDTH-1:0] <= diff_next;
          br_q                <= br_next;
          cnt_q               <= cnt_q + CNT_W'(1);
`ifdef XNOR_SUB_ERROR_METRIC_EN
          err_mask_o[WIDTH-1:0] <= mask_next;
`endif
          if (last_chunk) begin
            result_o[WIDTH] <= br_next;
            valid_o         <= 1'b1;
            state_q         <= S_DONE;
`ifdef XNOR_SUB_ERROR_METRIC_EN
            // The borrow chain is shared, so borrow_out never differs from the exact value
            err_mask_o[WIDTH] <= 1'b0;
            err_flag_o        <= flag_next;
`endif
          end
        end
        S_DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            ready_o <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
          ready_o <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xnor_based_borrow_serial_subtractor32.sv
// Self-checking bench for xnor_based_borrow_serial_subtractor32 (WIDTH=32, LOWER_WIDTH=8, CHUNK=8).
// The reference model uses word-level arithmetic. Exact = {0,a} - {0,b}. The approximate
// result keeps the exact upper bits and uses a^b for the low LOWER_WIDTH bits.
module tb_xnor_based_borrow_serial_subtractor32;

  localparam int unsigned W  = 32;
  localparam int unsigned LW = 8;
  localparam int unsigned CK = 8;
  localparam int unsigned N  = W / CK;

  logic         clk;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] min_i;
  logic [W-1:0] sub_i;
  logic         valid_o;
  logic         ready_i;
  logic [W:0]   result_o;
  logic         busy_o;
`ifdef XNOR_SUB_ERROR_METRIC_EN
  logic [W:0]   err_mask_o;
  logic         err_flag_o;
`endif

  int total;
  int bad;

  xnor_based_borrow_serial_subtractor32 #(
    .WIDTH(W), .LOWER_WIDTH(LW), .CHUNK(CK)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .min_i   (min_i),
    .sub_i   (sub_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .result_o(result_o),
    .busy_o  (busy_o)
`ifdef XNOR_SUB_ERROR_METRIC_EN
    ,
    .err_mask_o(err_mask_o),
    .err_flag_o(err_flag_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W:0] exact_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  function automatic logic [W:0] approx_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] low_mask;
    logic [W:0] ex;
    low_mask = (33'd1 << LW) - 33'd1;
    ex = exact_sub(a, b);
    return (ex & ~low_mask) | ({1'b0, a ^ b} & low_mask);
  endfunction

  // Issue one operation and stall the result for 'stall' cycles.
  // ready_i and valid_i toggle randomly while the operation is calculating.
  // No checks are made here; the calling test compares the outputs.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                       output logic [W:0] res, output int lat,
                       output bit hold_ok, output bit exit_ok);
    logic [W:0] snap;
    valid_i = 1'b1;
    min_i   = a;
    sub_i   = b;
    ready_i = 1'b0;
    @(negedge clk);
    lat     = 0;
    valid_i = 1'b0;
    while (valid_o !== 1'b1 && lat < 64) begin
      ready_i = 1'($urandom_range(0, 1));
      valid_i = 1'($urandom_range(0, 1));
      min_i   = $urandom;
      sub_i   = $urandom;
      @(negedge clk);
      lat++;
    end
    res     = result_o;
    snap    = result_o;
    hold_ok = 1'b1;
    for (int k = 0; k < stall; k++) begin
      ready_i = 1'b0;
      valid_i = 1'($urandom_range(0, 1));
      min_i   = $urandom;
      sub_i   = $urandom;
      @(negedge clk);
      if (valid_o !== 1'b1 || result_o !== snap || ready_o !== 1'b0 || busy_o !== 1'b1)
        hold_ok = 1'b0;
    end
    ready_i = 1'b1;
    valid_i = 1'b0;
    @(negedge clk);
    exit_ok = (valid_o === 1'b0) && (ready_o === 1'b1) && (busy_o === 1'b0);
    ready_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    min_i   = '0;
    sub_i   = '0;
    repeat (2) @(negedge clk);
    total++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold_ctrl: valid_o=%b busy_o=%b want 0 0", valid_o, busy_o);
    end
    total++;
    if (result_o !== 33'h0) begin
      bad++;
      $display("FAIL reset_hold_result: got %h want %h", result_o, 33'h0);
    end
    rst_i = 1'b0;
    @(negedge clk);
    total++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: ready_o=%b valid_o=%b busy_o=%b want 1 0 0",
               ready_o, valid_o, busy_o);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic [W:0]   vr [4];
    logic [W:0]   vm [4];
    logic [W:0]   res;
    int           lat;
    bit           h;
    bit           e;
    va[0] = 32'h00000064; vb[0] = 32'h00000001; vr[0] = 33'h0_00000065; vm[0] = 33'h006;
    va[1] = 32'h00000100; vb[1] = 32'h00000001; vr[1] = 33'h0_00000001; vm[1] = 33'h0FE;
    va[2] = 32'h12340000; vb[2] = 32'h00010000; vr[2] = 33'h0_12330000; vm[2] = 33'h000;
    va[3] = 32'h00000000; vb[3] = 32'h00000001; vr[3] = 33'h1_FFFFFF01; vm[3] = 33'h0FE;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], 0, res, lat, h, e);
      total++;
      if (res !== vr[i]) begin
        bad++;
        $display("FAIL directed_result[%0d]: got %h want %h", i, res, vr[i]);
      end
      total++;
      if (lat != N) begin
        bad++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, N);
      end
      total++;
      if (!e) begin
        bad++;
        $display("FAIL directed_exit[%0d]: valid_o=%b ready_o=%b want 0 1", i, valid_o, ready_o);
      end
`ifdef XNOR_SUB_ERROR_METRIC_EN
      total++;
      if (err_mask_o !== vm[i] || err_flag_o !== (|vm[i])) begin
        bad++;
        $display("FAIL directed_err[%0d]: got %h/%b want %h/%b", i, err_mask_o, err_flag_o,
                 vm[i], |vm[i]);
      end
`endif
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   res;
    int           lat;
    bit           h;
    bit           e;
    a = $urandom;
    b = $urandom;
    do_op(a, b, 5, res, lat, h, e);
    total++;
    if (res !== approx_sub(a, b)) begin
      bad++;
      $display("FAIL bp_result: got %h want %h", res, approx_sub(a, b));
    end
    total++;
    if (!h) begin
      bad++;
      $display("FAIL bp_hold: result/valid/ready changed during stall, now %h %b %b want %h 1 0",
               result_o, valid_o, ready_o, res);
    end
    total++;
    if (!e) begin
      bad++;
      $display("FAIL bp_exit: valid_o=%b ready_o=%b want 0 1", valid_o, ready_o);
    end
    total++;
    if (result_o !== res) begin
      bad++;
      $display("FAIL bp_idle_hold: got %h want %h", result_o, res);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   res;
    int           lat;
    bit           h;
    bit           e;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = a;
        1: a = '0;
        2: b = '1;
        3: b = a + 32'($urandom_range(1, 300));
        4: b = {24'h0, b[7:0]};
        default: ;
      endcase
      do_op(a, b, int'($urandom_range(0, 3)), res, lat, h, e);
      total++;
      if (res !== approx_sub(a, b)) begin
        bad++;
        $display("FAIL random_result[%0d]: a=%h b=%h got %h want %h", i, a, b, res,
                 approx_sub(a, b));
      end
      total++;
      if (lat != N || !h || !e) begin
        bad++;
        $display("FAIL random_timing[%0d]: latency %0d hold %0b exit %0b want %0d 1 1",
                 i, lat, h, e, N);
      end
`ifdef XNOR_SUB_ERROR_METRIC_EN
      total++;
      if (err_mask_o !== (approx_sub(a, b) ^ exact_sub(a, b))) begin
        bad++;
        $display("FAIL random_err[%0d]: got %h want %h", i, err_mask_o,
                 approx_sub(a, b) ^ exact_sub(a, b));
      end
`endif
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    int           t;
    a0 = $urandom; b0 = $urandom;
    a1 = $urandom; b1 = $urandom;
    ready_i = 1'b1;
    valid_i = 1'b1;
    min_i   = a0;
    sub_i   = b0;
    @(negedge clk);
    t     = 0;
    min_i = a1;
    sub_i = b1;
    while (valid_o !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (t != N || result_o !== approx_sub(a0, b0)) begin
      bad++;
      $display("FAIL b2b_first: at %0d got %h want at %0d %h", t, result_o, N,
               approx_sub(a0, b0));
    end
    @(negedge clk);
    t++;
    total++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_gap: valid_o=%b ready_o=%b want 0 1", valid_o, ready_o);
    end
    while (valid_o !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    valid_i = 1'b0;
    total++;
    if (t != 2 * N + 2 || result_o !== approx_sub(a1, b1)) begin
      bad++;
      $display("FAIL b2b_second: at %0d got %h want at %0d %h", t, result_o, 2 * N + 2,
               approx_sub(a1, b1));
    end
    @(negedge clk);
    ready_i = 1'b0;
    total++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_exit: valid_o=%b ready_o=%b want 0 1", valid_o, ready_o);
    end
  endtask

  task automatic test_reset_mid_calc;
    logic [W:0] res;
    int         lat;
    bit         h;
    bit         e;
    bit         seen;
    valid_i = 1'b1;
    min_i   = 32'hDEADBEEF;
    sub_i   = 32'h01234567;
    ready_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    total++;
    if (valid_o !== 1'b0 || result_o !== 33'h0 || ready_o !== 1'b1 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL midcalc_reset: valid=%b result=%h ready=%b busy=%b want 0 0 1 0",
               valid_o, result_o, ready_o, busy_o);
    end
    @(negedge clk);
    rst_i = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < int'(N) + 3; k++) begin
      @(negedge clk);
      if (valid_o !== 1'b0) seen = 1'b1;
    end
    ready_i = 1'b0;
    total++;
    if (seen) begin
      bad++;
      $display("FAIL midcalc_no_valid: valid_o rose after abort, want 0");
    end
    do_op(32'h00000064, 32'h00000001, 0, res, lat, h, e);
    total++;
    if (res !== 33'h0_00000065 || lat != N) begin
      bad++;
      $display("FAIL midcalc_next_op: got %h at %0d want %h at %0d", res, lat, 33'h0_00000065, N);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid_calc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
